// File: rtl/grid_overlay_gen.sv
// Raster grid overlay generator: flags pixels that fall on a configurable grid
// using per-axis phase/index counters, with outputs registered one cycle after the pixel.
module grid_overlay_gen #(
   parameter int XW = 11,
   parameter int YW = 10,
   parameter int PW = 8,
   parameter int DW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pix_valid,
   input  logic          frame_start,
   input  logic [XW-1:0] x,
   input  logic [YW-1:0] y,
   input  logic [XW-1:0] cfg_x0,
   input  logic [YW-1:0] cfg_y0,
   input  logic [PW-1:0] cfg_pitch,
   input  logic [DW-1:0] cfg_ndiv_x,
   input  logic [DW-1:0] cfg_ndiv_y,
   input  logic [1:0]    cfg_mode,
   output logic          grid_on,
   output logic          grid_major,
   output logic          grid_valid
);

   typedef enum logic [1:0] {
      MODE_OFF    = 2'b00,
      MODE_SOLID  = 2'b01,
      MODE_DOTTED = 2'b10,
      MODE_AXES   = 2'b11
   } mode_t;

   logic [XW-1:0] x0_q, x0_d;
   logic [YW-1:0] y0_q, y0_d;
   logic [PW-1:0] pitch_q, pitch_d;
   logic [DW-1:0] ndx_q, ndx_d, ndy_q, ndy_d;
   mode_t         mode_q, mode_d;

   logic [PW-1:0] phx_q, phx_d, phy_q, phy_d;
   logic [DW-1:0] idx_x_q, idx_x_d, idx_y_q, idx_y_d;
   logic [YW-1:0] prev_y_q, prev_y_d;
   logic          grid_on_q, grid_on_d, grid_major_q, grid_major_d, grid_valid_q, grid_valid_d;

   logic          cap, new_row, enable;
   logic [XW-1:0] x0_e;
   logic [YW-1:0] y0_e;
   logic [PW-1:0] pitch_e;
   logic [DW-1:0] ndx_e, ndy_e;
   mode_t         mode_e;
   logic [PW-1:0] phx_cur, phy_cur;
   logic [DW-1:0] idx_x_cur, idx_y_cur;
   logic          in_x, in_y, col_line, row_line, col_major, row_major, v_show, h_show;

   // Once the last line (index == ndiv) has passed, the phase parks at pitch-1
   // so it can never return to zero and draw a line beyond the grid extent.
   function automatic logic [PW+DW-1:0] advance(input logic [PW-1:0] ph, input logic [DW-1:0] idx,
                                                input logic [PW-1:0] pitch, input logic [DW-1:0] ndiv);
      logic [PW-1:0]    last;
      logic [PW+DW-1:0] res;
      last = pitch - PW'(1);
      if (idx >= ndiv) res = {(ph == last) ? ph : ph + PW'(1), idx};
      else if (ph == last) res = {PW'(0), idx + DW'(1)};
      else res = {ph + PW'(1), idx};
      return res;
   endfunction

   always_comb begin
      cap     = pix_valid & frame_start;
      x0_e    = cap ? cfg_x0 : x0_q;
      y0_e    = cap ? cfg_y0 : y0_q;
      pitch_e = cap ? cfg_pitch : pitch_q;
      ndx_e   = cap ? cfg_ndiv_x : ndx_q;
      ndy_e   = cap ? cfg_ndiv_y : ndy_q;
      mode_e  = cap ? mode_t'(cfg_mode) : mode_q;
      x0_d    = x0_e;
      y0_d    = y0_e;
      pitch_d = pitch_e;
      ndx_d   = ndx_e;
      ndy_d   = ndy_e;
      mode_d  = mode_e;

      if (x == x0_e) {phx_cur, idx_x_cur} = '0;
      else {phx_cur, idx_x_cur} = advance(phx_q, idx_x_q, pitch_e, ndx_e);

      // The first pixel of a frame always counts as a new row, even if y repeats.
      new_row = frame_start | (y != prev_y_q);
      if (!new_row) {phy_cur, idx_y_cur} = {phy_q, idx_y_q};
      else if (y == y0_e) {phy_cur, idx_y_cur} = '0;
      else {phy_cur, idx_y_cur} = advance(phy_q, idx_y_q, pitch_e, ndy_e);

      phx_d    = pix_valid ? phx_cur : phx_q;
      idx_x_d  = pix_valid ? idx_x_cur : idx_x_q;
      phy_d    = pix_valid ? phy_cur : phy_q;
      idx_y_d  = pix_valid ? idx_y_cur : idx_y_q;
      prev_y_d = pix_valid ? y : prev_y_q;

      in_x = (x >= x0_e) && ((idx_x_cur < ndx_e) || ((idx_x_cur == ndx_e) && (phx_cur == '0)));
      in_y = (y >= y0_e) && ((idx_y_cur < ndy_e) || ((idx_y_cur == ndy_e) && (phy_cur == '0)));
      col_line  = in_x && (phx_cur == '0);
      row_line  = in_y && (phy_cur == '0);
      col_major = (idx_x_cur == '0) || (idx_x_cur == ndx_e) || (idx_x_cur == (ndx_e >> 1));
      row_major = (idx_y_cur == '0) || (idx_y_cur == ndy_e) || (idx_y_cur == (ndy_e >> 1));

      // Dotting uses bit 0 of the offset from the origin along the line direction.
      v_show = col_line && ((mode_e != MODE_DOTTED) || !(y[0] ^ y0_e[0]));
      h_show = row_line && ((mode_e != MODE_DOTTED) || !(x[0] ^ x0_e[0]));

      enable = (mode_e != MODE_OFF) && (pitch_e >= PW'(2)) && (ndx_e != '0) && (ndy_e != '0)
               && pix_valid && in_x && in_y;
      grid_major_d = enable && ((v_show && col_major) || (h_show && row_major));
      grid_on_d    = (mode_e == MODE_AXES) ? grid_major_d : (enable && (v_show || h_show));
      grid_valid_d = pix_valid;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x0_q         <= '0;
         y0_q         <= '0;
         pitch_q      <= '0;
         ndx_q        <= '0;
         ndy_q        <= '0;
         mode_q       <= MODE_OFF;
         phx_q        <= '0;
         idx_x_q      <= '0;
         phy_q        <= '0;
         idx_y_q      <= '0;
         prev_y_q     <= '0;
         grid_on_q    <= 1'b0;
         grid_major_q <= 1'b0;
         grid_valid_q <= 1'b0;
      end else begin
         x0_q         <= x0_d;
         y0_q         <= y0_d;
         pitch_q      <= pitch_d;
         ndx_q        <= ndx_d;
         ndy_q        <= ndy_d;
         mode_q       <= mode_d;
         phx_q        <= phx_d;
         idx_x_q      <= idx_x_d;
         phy_q        <= phy_d;
         idx_y_q      <= idx_y_d;
         prev_y_q     <= prev_y_d;
         grid_on_q    <= grid_on_d;
         grid_major_q <= grid_major_d;
         grid_valid_q <= grid_valid_d;
      end
   end

   assign grid_on    = grid_on_q;
   assign grid_major = grid_major_q;
   assign grid_valid = grid_valid_q;

endmodule

// File: tb/tb_grid_overlay_gen.sv
// Directed bench for grid_overlay_gen: raster scans checked pixel-by-pixel against an
// arithmetic (modulo/divide) grid model, plus hand-picked spot pixels.
module tb_grid_overlay_gen;

   localparam int XW = 11, YW = 10, PW = 8, DW = 5;

   logic          clk = 1'b0;
   logic          rst, pix_valid, frame_start;
   logic [XW-1:0] x, cfg_x0;
   logic [YW-1:0] y, cfg_y0;
   logic [PW-1:0] cfg_pitch;
   logic [DW-1:0] cfg_ndiv_x, cfg_ndiv_y;
   logic [1:0]    cfg_mode;
   logic          grid_on, grid_major, grid_valid;

   int tests_run = 0, tests_failed = 0;

   // Bench copy of the frame configuration, latched on frame_start with a valid pixel.
   int m_x0, m_y0, m_pitch, m_ndx, m_ndy, m_mode;

   // Expected outputs for the pixel driven on the previous cycle.
   bit   have_prev = 0;
   logic exp_on, exp_maj, exp_v;
   int   prev_x, prev_y;
   bit   hand_pending = 0;
   logic hand_val;

   int   hx[$], hy[$];
   logic hv[$];

   grid_overlay_gen #(.XW(XW), .YW(YW), .PW(PW), .DW(DW)) dut (
      .clk(clk), .rst(rst), .pix_valid(pix_valid), .frame_start(frame_start),
      .x(x), .y(y), .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_pitch(cfg_pitch),
      .cfg_ndiv_x(cfg_ndiv_x), .cfg_ndiv_y(cfg_ndiv_y), .cfg_mode(cfg_mode),
      .grid_on(grid_on), .grid_major(grid_major), .grid_valid(grid_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic check_output(input string tag, input logic obs, input logic exp, input int xi, input int yi);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("[TB] FAIL %s at (%0d,%0d): got %b expected %b", tag, xi, yi, obs, exp);
      end
   endtask

   task automatic model(input int xi, input int yi, output logic on, output logic maj);
      int dx, dy, ci, ri;
      bit vs, hs, cm, rm;
      on = 1'b0;
      maj = 1'b0;
      if (m_mode != 0 && m_pitch >= 2 && m_ndx != 0 && m_ndy != 0) begin
         dx = xi - m_x0;
         dy = yi - m_y0;
         if (dx >= 0 && dy >= 0 && dx <= m_pitch * m_ndx && dy <= m_pitch * m_ndy) begin
            ci = dx / m_pitch;
            ri = dy / m_pitch;
            cm = (ci == 0) || (ci == m_ndx) || (ci == m_ndx / 2);
            rm = (ri == 0) || (ri == m_ndy) || (ri == m_ndy / 2);
            vs = (dx % m_pitch == 0) && (m_mode != 2 || dy % 2 == 0);
            hs = (dy % m_pitch == 0) && (m_mode != 2 || dx % 2 == 0);
            maj = (vs && cm) || (hs && rm);
            on = (m_mode == 3) ? maj : (vs || hs);
         end
      end
   endtask

   // One clock: check the previous pixel's outputs, then drive the next pixel.
   task automatic apply_stimulus(input logic v, input logic fs, input int xi, input int yi);
      @(posedge clk);
      #1;
      if (have_prev) begin
         check_output("grid_valid", grid_valid, exp_v, prev_x, prev_y);
         check_output("grid_on", grid_on, exp_on, prev_x, prev_y);
         check_output("grid_major", grid_major, exp_maj, prev_x, prev_y);
         if (hand_pending) check_output("hand_point", grid_on, hand_val, prev_x, prev_y);
      end
      pix_valid   = v;
      frame_start = fs;
      x = xi[XW-1:0];
      y = yi[YW-1:0];
      if (v && fs) begin
         m_x0 = int'(cfg_x0); m_y0 = int'(cfg_y0); m_pitch = int'(cfg_pitch);
         m_ndx = int'(cfg_ndiv_x); m_ndy = int'(cfg_ndiv_y); m_mode = int'(cfg_mode);
      end
      if (v) model(xi, yi, exp_on, exp_maj);
      else begin
         exp_on = 1'b0;
         exp_maj = 1'b0;
      end
      exp_v = v;
      prev_x = xi;
      prev_y = yi;
      hand_pending = 0;
      if (v) foreach (hx[i]) if (hx[i] == xi && hy[i] == yi) begin
         hand_pending = 1;
         hand_val = hv[i];
      end
      have_prev = 1;
   endtask

   task automatic scan(input bit fs_first, input int y_lo, input int y_hi, input int x_hi, input bit gaps);
      bit first;
      int n;
      first = fs_first;
      n = 0;
      for (int yy = y_lo; yy <= y_hi; yy++) begin
         for (int xx = 0; xx <= x_hi; xx++) begin
            if (gaps && (n % 3 == 2)) apply_stimulus(1'b0, 1'b0, xx + 5, yy + 3);
            n++;
            apply_stimulus(1'b1, first, xx, yy);
            first = 0;
         end
      end
   endtask

   task automatic set_cfg(input int x0, input int y0, input int pitch, input int ndx, input int ndy, input int mode);
      cfg_x0 = x0[XW-1:0];
      cfg_y0 = y0[YW-1:0];
      cfg_pitch = pitch[PW-1:0];
      cfg_ndiv_x = ndx[DW-1:0];
      cfg_ndiv_y = ndy[DW-1:0];
      cfg_mode = mode[1:0];
   endtask

   task automatic hand(input int xi, input int yi, input logic v);
      hx.push_back(xi);
      hy.push_back(yi);
      hv.push_back(v);
   endtask

   task automatic clear_hand();
      hx.delete();
      hy.delete();
      hv.delete();
   endtask

   task automatic model_reset();
      m_x0 = 0; m_y0 = 0; m_pitch = 0; m_ndx = 0; m_ndy = 0; m_mode = 0;
   endtask

   initial begin
      rst = 1'b1;
      pix_valid = 1'b0;
      frame_start = 1'b0;
      x = '0;
      y = '0;
      set_cfg(20, 20, 75, 10, 8, 1);
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_output("reset_on", grid_on, 1'b0, 0, 0);
      check_output("reset_major", grid_major, 1'b0, 0, 0);
      check_output("reset_valid", grid_valid, 1'b0, 0, 0);
      rst = 1'b0;

      // Pixels before any frame_start must stay dark even on grid positions.
      for (int xx = 18; xx <= 22; xx++) apply_stimulus(1'b1, 1'b0, xx, 20);

      // Solid, main configuration.
      hand(20, 20, 1); hand(100, 20, 1); hand(95, 21, 1); hand(770, 22, 1);
      hand(771, 22, 0); hand(780, 20, 0); hand(19, 20, 0); hand(50, 21, 0);
      scan(1, 0, 22, 799, 0);

      // Dotted.
      clear_hand();
      set_cfg(20, 20, 75, 10, 8, 2);
      hand(95, 21, 0); hand(95, 22, 1); hand(21, 20, 0); hand(22, 20, 1); hand(20, 21, 0);
      scan(1, 0, 22, 120, 0);

      // Border plus centre axes: tall narrow frame, then a wide short one.
      clear_hand();
      set_cfg(20, 20, 75, 10, 8, 3);
      hand(20, 95, 1); hand(22, 95, 0); hand(22, 320, 1); hand(22, 20, 1); hand(21, 21, 0); hand(22, 321, 0);
      scan(1, 0, 321, 24, 0);
      clear_hand();
      hand(95, 21, 0); hand(395, 21, 1); hand(770, 21, 1); hand(95, 20, 1); hand(170, 21, 0);
      scan(1, 0, 21, 799, 0);

      // Pitch change mid-frame takes effect only at the next frame_start.
      clear_hand();
      set_cfg(2, 1, 4, 4, 3, 1);
      scan(1, 0, 5, 29, 0);
      cfg_pitch = 8'd5;
      hand(6, 7, 1); hand(7, 7, 0);
      scan(0, 6, 15, 29, 0);
      clear_hand();
      hand(7, 7, 1); hand(6, 7, 0);
      scan(1, 0, 15, 29, 0);

      // Reset mid-frame: outputs clear at once and stay dark until frame_start.
      clear_hand();
      scan(1, 0, 7, 29, 0);
      for (int xx = 0; xx <= 10; xx++) apply_stimulus(1'b1, 1'b0, xx, 8);
      #2;
      rst = 1'b1;
      #1;
      check_output("midreset_on", grid_on, 1'b0, 10, 8);
      check_output("midreset_major", grid_major, 1'b0, 10, 8);
      check_output("midreset_valid", grid_valid, 1'b0, 10, 8);
      have_prev = 0;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      hand(7, 11, 0);
      for (int xx = 11; xx <= 29; xx++) apply_stimulus(1'b1, 1'b0, xx, 8);
      scan(0, 9, 15, 29, 0);
      clear_hand();
      hand(7, 11, 1);
      scan(1, 0, 15, 29, 0);

      // Degenerate configurations force the outputs low.
      clear_hand();
      hand(0, 0, 0); hand(3, 0, 0);
      set_cfg(0, 0, 1, 4, 4, 1);
      scan(1, 0, 3, 9, 0);
      set_cfg(0, 0, 3, 0, 2, 1);
      scan(1, 0, 3, 9, 0);
      set_cfg(0, 0, 3, 2, 2, 0);
      scan(1, 0, 3, 9, 0);

      // Index saturation: no lines beyond the last division.
      clear_hand();
      set_cfg(0, 0, 3, 2, 2, 1);
      hand(6, 0, 1); hand(9, 0, 0); hand(6, 4, 1); hand(9, 4, 0); hand(3, 8, 0); hand(12, 1, 0);
      scan(1, 0, 9, 19, 0);

      // Pitch 2 without and with pix_valid gaps must give the same pattern.
      clear_hand();
      set_cfg(1, 1, 2, 4, 4, 1);
      hand(3, 4, 1); hand(4, 4, 0);
      scan(1, 0, 11, 13, 0);
      scan(1, 0, 11, 13, 1);
      apply_stimulus(1'b0, 1'b0, 0, 0);
      apply_stimulus(1'b0, 1'b0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
